high_fanin_add_tree: RTL and testbench

Pipelined binary adder tree that reduces `NUM_INPUTS` unsigned operands to one full-precision sum. It is the fan-in counterpart to the high-fanout adder exercise in the timing modules: many registers converge on one result instead of one register driving many adders. Every tree level is registered, so there is one two-input adder between any two flops regardless of `NUM_INPUTS`. A `valid` pipeline and a global stall enable travel alongside the data.

---
 rtl/high_fanin_add_pkg.sv | 31 +++
 rtl/high_fanin_add_level.sv | 51 +++++
 rtl/high_fanin_add_tree.sv | 86 ++++++++
 tb/tb_high_fanin_add_tree.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/high_fanin_add_pkg.sv
// Sizing helpers for the pipelined fan-in adder tree: level count, entries per
// level, and bit offsets used to pack all levels into one flat vector.
package high_fanin_add_pkg;

    function automatic int tree_levels(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    function automatic int level_count(input int n, input int k);
        int c;
        c = n;
        for (int i = 0; i < k; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    // Bit position where level k starts when levels 0..k-1 are packed back to back.
    function automatic int level_offset(input int n, input int w, input int k);
        int off;
        int c;
        off = 0;
        c   = n;
        for (int i = 0; i < k; i++) begin
            off = off + c * (w + i);
            c   = (c + 1) / 2;
        end
        return off;
    endfunction

endpackage

// File: rtl/high_fanin_add_level.sv
// One registered reduction level: pairs of entries are added, an odd last entry
// is zero-extended and registered so every path has the same depth.
module high_fanin_add_level
    import high_fanin_add_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int IN_COUNT = 2,
    localparam int OUT_COUNT = (IN_COUNT + 1) / 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                valid_in,
    input  logic [IN_WIDTH-1:0] in [IN_COUNT],
    output logic                valid_out,
    output logic [IN_WIDTH:0]   out [OUT_COUNT]
);

    logic [IN_WIDTH:0] sum_next [OUT_COUNT];
    logic [IN_WIDTH:0] sum_reg  [OUT_COUNT];
    logic              valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < OUT_COUNT; gi++) begin : g_entry
            if (2 * gi + 1 < IN_COUNT) begin : g_pair
                assign sum_next[gi] = {1'b0, in[2*gi]} + {1'b0, in[2*gi+1]};
            end else begin : g_pass
                assign sum_next[gi] = {1'b0, in[2*gi]};
            end
            assign out[gi] = sum_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            for (int i = 0; i < OUT_COUNT; i++) begin
                sum_reg[i] <= '0;
            end
        end else if (en) begin
            valid_reg <= valid_in;
            for (int i = 0; i < OUT_COUNT; i++) begin
                sum_reg[i] <= sum_next[i];
            end
        end
    end

    assign valid_out = valid_reg;

endmodule

// File: rtl/high_fanin_add_tree.sv
// Pipelined binary adder tree reducing NUM_INPUTS unsigned operands to one
// full-precision sum, with a valid pipeline and a global stall enable.
module high_fanin_add_tree
    import high_fanin_add_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_INPUTS = 8,
    localparam int SUM_WIDTH = DATA_WIDTH + tree_levels(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] in [NUM_INPUTS],
    output logic                  valid_out,
    output logic [SUM_WIDTH-1:0]  out
);

    localparam int LEVELS     = tree_levels(NUM_INPUTS);
    localparam int TOTAL_BITS = level_offset(NUM_INPUTS, DATA_WIDTH, LEVELS + 1);

    // Every level's registered entries live in one flat vector so each level
    // can slice its predecessor regardless of how the widths grow.
    logic [TOTAL_BITS-1:0]  data_flat;
    logic [LEVELS:0]        valid_chain;
    logic [DATA_WIDTH-1:0]  stage0_reg [NUM_INPUTS];
    logic                   stage0_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage0_valid_reg <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                stage0_reg[i] <= '0;
            end
        end else if (en) begin
            stage0_valid_reg <= valid_in;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                stage0_reg[i] <= in[i];
            end
        end
    end

    assign valid_chain[0] = stage0_valid_reg;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_stage0
            assign data_flat[gi*DATA_WIDTH +: DATA_WIDTH] = stage0_reg[gi];
        end

        for (gi = 1; gi <= LEVELS; gi++) begin : g_level
            localparam int IN_W    = DATA_WIDTH + gi - 1;
            localparam int IN_C    = level_count(NUM_INPUTS, gi - 1);
            localparam int OUT_C   = level_count(NUM_INPUTS, gi);
            localparam int IN_OFF  = level_offset(NUM_INPUTS, DATA_WIDTH, gi - 1);
            localparam int OUT_OFF = level_offset(NUM_INPUTS, DATA_WIDTH, gi);

            logic [IN_W-1:0] lvl_in  [IN_C];
            logic [IN_W:0]   lvl_out [OUT_C];

            for (gj = 0; gj < IN_C; gj++) begin : g_unpack
                assign lvl_in[gj] = data_flat[IN_OFF + gj*IN_W +: IN_W];
            end
            for (gj = 0; gj < OUT_C; gj++) begin : g_pack
                assign data_flat[OUT_OFF + gj*(IN_W+1) +: IN_W+1] = lvl_out[gj];
            end

            high_fanin_add_level #(
                .IN_WIDTH (IN_W),
                .IN_COUNT (IN_C)
            ) u_level (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .valid_in  (valid_chain[gi-1]),
                .in        (lvl_in),
                .valid_out (valid_chain[gi]),
                .out       (lvl_out)
            );
        end
    endgenerate

    assign out       = data_flat[level_offset(NUM_INPUTS, DATA_WIDTH, LEVELS) +: SUM_WIDTH];
    assign valid_out = valid_chain[LEVELS];

endmodule

// File: tb/tb_high_fanin_add_tree.sv
// Bench for high_fanin_add_tree: three configurations (8x8, 5x4, 1x8) share clk,
// rst and en; a scoreboard of accepted sets predicts every output cycle.
module tb_high_fanin_add_tree;
    import high_fanin_add_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic vin [3];
    logic vout [3];
    int unsigned opnd [3][8];

    logic [7:0]  in0 [8];
    logic [3:0]  in1 [5];
    logic [7:0]  in2 [1];
    logic [10:0] out0;
    logic [6:0]  out1;
    logic [7:0]  out2;
    logic [31:0] obs_o [3];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 8; i++) in0[i] = 8'(opnd[0][i]);
        for (int i = 0; i < 5; i++) in1[i] = 4'(opnd[1][i]);
        in2[0] = 8'(opnd[2][0]);
    end

    assign obs_o[0] = 32'(out0);
    assign obs_o[1] = 32'(out1);
    assign obs_o[2] = 32'(out2);

    high_fanin_add_tree #(.DATA_WIDTH(8), .NUM_INPUTS(8)) dut0 (
        .clk(clk), .rst(rst), .en(en), .valid_in(vin[0]), .in(in0),
        .valid_out(vout[0]), .out(out0));
    high_fanin_add_tree #(.DATA_WIDTH(4), .NUM_INPUTS(5)) dut1 (
        .clk(clk), .rst(rst), .en(en), .valid_in(vin[1]), .in(in1),
        .valid_out(vout[1]), .out(out1));
    high_fanin_add_tree #(.DATA_WIDTH(8), .NUM_INPUTS(1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .valid_in(vin[2]), .in(in2),
        .valid_out(vout[2]), .out(out2));

    // Reference model: each accepted set is due a fixed number of enabled edges
    // after it was sampled; stalls do not count, reset forgets everything.
    typedef struct {
        int          d;
        int          due;
        int unsigned sum;
    } rec_t;

    rec_t        q[$];
    int          ecnt;
    logic        exp_v [3];
    int unsigned exp_o [3];
    logic        chk_o [3];
    int          checks = 0;
    int          errors = 0;

    int nin   [3] = '{8, 5, 1};
    int dmask [3] = '{255, 15, 255};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int unsigned set_sum(input int d);
        int unsigned s;
        s = 0;
        for (int i = 0; i < nin[d]; i++) s += opnd[d][i];
        return s;
    endfunction

    task automatic cyc(input string label);
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            ecnt = 0;
            for (int d = 0; d < 3; d++) begin
                exp_v[d] = 1'b0; exp_o[d] = 0; chk_o[d] = 1'b1;
            end
        end else if (en) begin
            ecnt++;
            for (int d = 0; d < 3; d++)
                if (vin[d]) q.push_back('{d, ecnt + tree_levels(nin[d]), set_sum(d)});
            for (int d = 0; d < 3; d++) begin
                int idx;
                idx = -1;
                foreach (q[i]) if (idx < 0 && q[i].d == d) idx = i;
                if (idx >= 0 && q[idx].due == ecnt) begin
                    exp_v[d] = 1'b1; exp_o[d] = q[idx].sum; chk_o[d] = 1'b1;
                    q.delete(idx);
                end else begin
                    exp_v[d] = 1'b0; chk_o[d] = 1'b0;
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s dut%0d valid_out", label, d), 32'(vout[d]), 32'(exp_v[d]));
            if (chk_o[d]) check($sformatf("%s dut%0d out", label, d), obs_o[d], 32'(exp_o[d]));
        end
        $display("cycle %s: en=%0b rst=%0b vout=%0b%0b%0b out=%0d/%0d/%0d", label, en, rst,
                 vout[0], vout[1], vout[2], out0, out1, out2);
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 3; d++) vin[d] = 1'b0;
    endtask

    task automatic rand_set(input int d);
        for (int i = 0; i < 8; i++) opnd[d][i] = $urandom & dmask[d];
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        idle_inputs();
        for (int d = 0; d < 3; d++) for (int i = 0; i < 8; i++) opnd[d][i] = 0;
        cyc("reset0");
        cyc("reset1");

        // Directed sets: 1..8, all-15 odd tree, single operand 9.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) opnd[0][i] = i + 1;
        for (int i = 0; i < 5; i++) opnd[1][i] = 15;
        opnd[2][0] = 9;
        for (int d = 0; d < 3; d++) vin[d] = 1'b1;
        cyc("basic");
        idle_inputs();
        for (int c = 0; c < 6; c++) cyc("basic_drain");

        // Maximum operands then zero, back to back.
        for (int i = 0; i < 8; i++) opnd[0][i] = 255;
        vin[0] = 1'b1;
        cyc("max");
        for (int i = 0; i < 8; i++) opnd[0][i] = 0;
        cyc("zero");
        idle_inputs();
        for (int c = 0; c < 5; c++) cyc("max_drain");

        // Three sets with a two-cycle stall after the second; stalled inputs ignored.
        for (int d = 0; d < 3; d++) begin rand_set(d); vin[d] = 1'b1; end
        cyc("stream_a");
        for (int d = 0; d < 3; d++) rand_set(d);
        cyc("stream_b");
        en = 1'b0;
        for (int d = 0; d < 3; d++) rand_set(d);
        cyc("stall0");
        cyc("stall1");
        en = 1'b1;
        for (int d = 0; d < 3; d++) rand_set(d);
        cyc("stream_c");
        idle_inputs();
        for (int c = 0; c < 6; c++) cyc("stream_drain");

        // Reset two cycles after a set, then a new set right after reset.
        for (int d = 0; d < 3; d++) begin rand_set(d); vin[d] = 1'b1; end
        cyc("pre_rst");
        idle_inputs();
        cyc("pre_rst_wait");
        rst = 1'b1;
        cyc("mid_rst");
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin rand_set(d); vin[d] = 1'b1; end
        cyc("post_rst");
        idle_inputs();
        for (int c = 0; c < 6; c++) cyc("post_rst_drain");

        // Random traffic with random stalls and occasional reset (with en high).
        for (int c = 0; c < 60; c++) begin
            rst = ($urandom_range(0, 24) == 0);
            en  = ($urandom_range(0, 3) != 0);
            for (int d = 0; d < 3; d++) begin
                rand_set(d);
                vin[d] = 1'($urandom_range(0, 1));
            end
            cyc("random");
        end
        rst = 1'b0; en = 1'b1;
        idle_inputs();
        for (int c = 0; c < 6; c++) cyc("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
